// File: rtl/jtl_vc050.sv
// Clocked model of one SFQ Josephson transmission line delay stage.
// Each transition on `in` is a pulse; accepted pulses toggle `out` D ticks later.
module jtl_vc050 #(
  parameter int BIAS_X10     = 25,
  parameter int DELAY_NOM    = 50,
  parameter int DELAY_SLOPE  = 4,
  parameter int BIAS_MIN_X10 = 18,
  parameter int MIN_SEP      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic drop
);

  localparam int DRaw     = DELAY_NOM + (25 - BIAS_X10) * DELAY_SLOPE;
  localparam int D        = (DRaw < 1) ? 1 : ((DRaw > 255) ? 255 : DRaw);
  localparam int SepClamp = (MIN_SEP < 1) ? 1 : ((MIN_SEP > 65535) ? 65535 : MIN_SEP);
  localparam logic [15:0] SepMax = 16'(SepClamp);
  localparam logic BiasOk = (BIAS_X10 >= BIAS_MIN_X10);

  logic           in_q;
  logic           out_q, out_d;
  logic           drop_q, drop_d;
  logic [D-1:0]   line_q, line_d;
  logic [15:0]    sep_q, sep_d;
  logic           pulse, accept;

  always_comb begin
    pulse  = in ^ in_q;
    // sep_q counts ticks since the last acceptance, so >= SepMax means the window is clear
    accept = BiasOk && pulse && (sep_q >= SepMax);

    line_d[0] = accept;
    for (int i = 1; i < D; i++) begin
      line_d[i] = line_q[i-1];
    end

    out_d  = out_q ^ line_q[D-1];
    drop_d = pulse & ~accept;

    if (accept) begin
      sep_d = 16'd1;
    end else if (sep_q >= SepMax) begin
      sep_d = SepMax;
    end else begin
      sep_d = sep_q + 16'd1;
    end

    // Reset discards in-flight pulses and any pulse seen on the same edge
    if (rst) begin
      line_d = '0;
      out_d  = 1'b0;
      drop_d = 1'b0;
      sep_d  = SepMax;
    end
  end

  always_ff @(posedge clk) begin
    in_q   <= in;
    out_q  <= out_d;
    drop_q <= drop_d;
    line_q <= line_d;
    sep_q  <= sep_d;
  end

  assign out  = out_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_jtl_vc050.sv
// Directed bench for jtl_vc050: default bias (D=50), BIAS_X10=20 (D=70) and
// BIAS_X10=15 (below switching threshold) instances share one stimulus.
module tb_jtl_vc050;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic [2:0] out;
  logic [2:0] drop;

  always #5 clk = ~clk;

  jtl_vc050 u_def (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .out  (out[0]),
    .drop (drop[0])
  );

  jtl_vc050 #(.BIAS_X10(20)) u_b20 (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .out  (out[1]),
    .drop (drop[1])
  );

  jtl_vc050 #(.BIAS_X10(15)) u_b15 (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .out  (out[2]),
    .drop (drop[2])
  );

  int   checks = 0;
  int   errors = 0;
  logic out_h  [3][0:400];
  logic drop_h [3][0:400];
  int   n_tog  [3];
  int   n_drop [3];
  logic prev   [3];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset 5 cycles, then run n ticks; tick t is the t-th edge after release.
  // Toggles ta/tb/tc land on edge t; rst is high only at edge rst_at.
  task automatic run_scn(input int ta, input int tb, input int tc, input int rst_at,
                         input int n);
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_tog[d]     = 0;
      n_drop[d]    = 0;
      prev[d]      = out[d];
      out_h[d][0]  = out[d];
      drop_h[d][0] = drop[d];
    end
    for (int t = 1; t <= n; t++) begin
      if (t == ta || t == tb || t == tc) in = ~in;
      rst = (t == rst_at);
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        out_h[d][t]  = out[d];
        drop_h[d][t] = drop[d];
        if (out[d] !== prev[d]) n_tog[d]++;
        if (drop[d] === 1'b1) n_drop[d]++;
        prev[d] = out[d];
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in  = 1'b1;

    // Quiet line: no pulse at reset release
    run_scn(-1, -1, -1, -1, 100);
    check_eq("rst_out",     int'(out_h[0][0]), 0);
    check_eq("rst_drop",    int'(drop_h[0][0]), 0);
    check_eq("idle_tog",    n_tog[0], 0);
    check_eq("idle_drop",   n_drop[0], 0);

    // Single pulse
    run_scn(200, -1, -1, -1, 310);
    check_eq("s1_out249",   int'(out_h[0][249]), 0);
    check_eq("s1_out250",   int'(out_h[0][250]), 1);
    check_eq("s1_out300",   int'(out_h[0][300]), 1);
    check_eq("s1_tog",      n_tog[0], 1);
    check_eq("s1_drop",     n_drop[0], 0);
    check_eq("b20_out269",  int'(out_h[1][269]), 0);
    check_eq("b20_out270",  int'(out_h[1][270]), 1);
    check_eq("b15_drop",    n_drop[2], 1);
    check_eq("b15_tog",     n_tog[2], 0);

    // Second pulse inside the separation window
    run_scn(200, 210, -1, -1, 310);
    check_eq("s2_out250",   int'(out_h[0][250]), 1);
    check_eq("s2_tog",      n_tog[0], 1);
    check_eq("s2_drop209",  int'(drop_h[0][209]), 0);
    check_eq("s2_drop210",  int'(drop_h[0][210]), 1);
    check_eq("s2_drop211",  int'(drop_h[0][211]), 0);
    check_eq("s2_ndrop",    n_drop[0], 1);
    check_eq("b20_s2_tog",  n_tog[1], 1);
    check_eq("b15_s2_drop", n_drop[2], 2);

    // Three pulses exactly MIN_SEP apart
    run_scn(200, 220, 240, -1, 320);
    check_eq("s3_out269",   int'(out_h[0][269]), 1);
    check_eq("s3_out270",   int'(out_h[0][270]), 0);
    check_eq("s3_out290",   int'(out_h[0][290]), 1);
    check_eq("s3_tog",      n_tog[0], 3);
    check_eq("s3_drop",     n_drop[0], 0);
    check_eq("b20_s3_tog",  n_tog[1], 3);

    // Reset mid-flight cancels the pending output
    run_scn(200, 260, -1, 230, 340);
    check_eq("s4_out300",   int'(out_h[0][300]), 0);
    check_eq("s4_out309",   int'(out_h[0][309]), 0);
    check_eq("s4_out310",   int'(out_h[0][310]), 1);
    check_eq("s4_tog",      n_tog[0], 1);
    check_eq("b20_s4_out330", int'(out_h[1][330]), 1);
    check_eq("b20_s4_tog",  n_tog[1], 1);

    // MIN_SEP-1 dropped; a drop does not restart the window
    run_scn(200, 219, 220, -1, 300);
    check_eq("s5_drop219",  int'(drop_h[0][219]), 1);
    check_eq("s5_ndrop",    n_drop[0], 1);
    check_eq("s5_out270",   int'(out_h[0][270]), 0);
    check_eq("s5_tog",      n_tog[0], 2);

    // Back-to-back toggles
    run_scn(200, 201, -1, -1, 300);
    check_eq("s6_drop201",  int'(drop_h[0][201]), 1);
    check_eq("s6_tog",      n_tog[0], 1);

    // Pulse on the same edge as reset is ignored
    run_scn(230, -1, -1, 230, 300);
    check_eq("s7_tog",      n_tog[0], 0);
    check_eq("s7_drop",     n_drop[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
